// File: rtl/wb_write_arbiter_if.sv
// Bundles the pipeline W-stage, late-return, scoreboard query and GRF write-port
// signals of wb_write_arbiter; slave is the arbiter side, master the surroundings.
interface wb_write_arbiter_if;
  logic        w_we;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic        late_valid;
  logic [4:0]  late_addr;
  logic [31:0] late_data;
  logic        late_ready;
  logic [4:0]  q_addr;
  logic        q_pending;
  logic        stall_req;
  logic        grf_we;
  logic [4:0]  grf_addr;
  logic [31:0] grf_data;
  logic [31:0] stat_stall_cnt;
  logic [15:0] stat_kill_cnt;

  modport slave (
    input  w_we, w_addr, w_data, late_valid, late_addr, late_data, q_addr,
    output late_ready, q_pending, stall_req, grf_we, grf_addr, grf_data,
           stat_stall_cnt, stat_kill_cnt
  );

  modport master (
    output w_we, w_addr, w_data, late_valid, late_addr, late_data, q_addr,
    input  late_ready, q_pending, stall_req, grf_we, grf_addr, grf_data,
           stat_stall_cnt, stat_kill_cnt
  );
endinterface

// File: rtl/wb_write_arbiter.sv
// GRF write-port arbiter: pipeline W stage has priority, late returns queue in a small FIFO.
// Define WB_ARB_STATS_EN to build the stall/kill statistics counters.
module wb_write_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               reset,
  wb_write_arbiter_if.slave bus
);
  localparam int          AW         = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE    = (AW+1)'(1);
  localparam logic [3:0]  STARVE_LIM = 4'(STARVE_LIMIT);

  logic [DEPTH-1:0] ent_valid_q, ent_valid_d;
  logic [4:0]       ent_addr_q [DEPTH];
  logic [4:0]       ent_addr_d [DEPTH];
  logic [31:0]      ent_data_q [DEPTH];
  logic [31:0]      ent_data_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [3:0]       starve_q, starve_d;
  logic             stall_q, stall_d;
  logic             grf_we_q, grf_we_d;
  logic [4:0]       grf_addr_q, grf_addr_d;
  logic [31:0]      grf_data_q, grf_data_d;

  logic          live_w, empty, full, head_live, pop, grant_fifo, push, push_store, q_hit;
  logic [AW-1:0] head_idx, wr_idx;

  assign live_w   = bus.w_we && (bus.w_addr != 5'd0);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_idx = rd_ptr_q[AW-1:0];
  assign wr_idx   = wr_ptr_q[AW-1:0];

  // A head killed by this cycle's pipeline write is treated as already invalid.
  assign head_live  = !empty && ent_valid_q[head_idx]
                      && !(live_w && (ent_addr_q[head_idx] == bus.w_addr));
  assign pop        = !empty && (!head_live || !live_w);
  assign grant_fifo = head_live && !live_w;
  assign push       = bus.late_valid && !full;
  // Returns to $0 or to a register the pipeline is writing now never occupy a slot.
  assign push_store = push && (bus.late_addr != 5'd0)
                      && !(live_w && (bus.late_addr == bus.w_addr));

  always_comb begin
    ent_valid_d = ent_valid_q;
    ent_addr_d  = ent_addr_q;
    ent_data_d  = ent_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_w && ent_valid_q[i] && (ent_addr_q[i] == bus.w_addr)) begin
        ent_valid_d[i] = 1'b0;
      end
    end
    if (pop) begin
      ent_valid_d[head_idx] = 1'b0;
      rd_ptr_d              = rd_ptr_q + PTR_ONE;
    end
    if (push_store) begin
      ent_valid_d[wr_idx] = 1'b1;
      ent_addr_d[wr_idx]  = bus.late_addr;
      ent_data_d[wr_idx]  = bus.late_data;
      wr_ptr_d            = wr_ptr_q + PTR_ONE;
    end
  end

  always_comb begin
    grf_we_d   = 1'b0;
    grf_addr_d = grf_addr_q;
    grf_data_d = grf_data_q;
    if (live_w) begin
      grf_we_d   = 1'b1;
      grf_addr_d = bus.w_addr;
      grf_data_d = bus.w_data;
    end else if (grant_fifo) begin
      grf_we_d   = 1'b1;
      grf_addr_d = ent_addr_q[head_idx];
      grf_data_d = ent_data_q[head_idx];
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (empty || pop) begin
      starve_d = 4'd0;
    end else if (head_live && (starve_q < STARVE_LIM)) begin
      starve_d = starve_q + 4'd1;
    end
    stall_d = (starve_d == STARVE_LIM);
  end

  always_comb begin
    q_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid_q[i] && (ent_addr_q[i] == bus.q_addr)) begin
        q_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr_q[i] <= 5'd0;
        ent_data_q[i] <= 32'd0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      starve_q   <= 4'd0;
      stall_q    <= 1'b0;
      grf_we_q   <= 1'b0;
      grf_addr_q <= 5'd0;
      grf_data_q <= 32'd0;
    end else begin
      ent_valid_q <= ent_valid_d;
      ent_addr_q  <= ent_addr_d;
      ent_data_q  <= ent_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      starve_q    <= starve_d;
      stall_q     <= stall_d;
      grf_we_q    <= grf_we_d;
      grf_addr_q  <= grf_addr_d;
      grf_data_q  <= grf_data_d;
    end
  end

  assign bus.late_ready = !full;
  assign bus.q_pending  = q_hit && (bus.q_addr != 5'd0);
  assign bus.stall_req  = stall_q;
  assign bus.grf_we     = grf_we_q;
  assign bus.grf_addr   = grf_addr_q;
  assign bus.grf_data   = grf_data_q;

`ifdef WB_ARB_STATS_EN
  logic [31:0] stat_stall_q, stat_stall_d;
  logic [15:0] stat_kill_q, stat_kill_d;
  logic [4:0]  kill_num;
  logic [16:0] kill_sum;

  always_comb begin
    kill_num = 5'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_w && ent_valid_q[i] && (ent_addr_q[i] == bus.w_addr)) begin
        kill_num = kill_num + 5'd1;
      end
    end
    if (push && live_w && (bus.late_addr == bus.w_addr)) begin
      kill_num = kill_num + 5'd1;
    end
    kill_sum     = {1'b0, stat_kill_q} + {12'd0, kill_num};
    stat_kill_d  = kill_sum[16] ? 16'hFFFF : kill_sum[15:0];
    stat_stall_d = stall_q ? (stat_stall_q + 32'd1) : stat_stall_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_stall_q <= 32'd0;
      stat_kill_q  <= 16'd0;
    end else begin
      stat_stall_q <= stat_stall_d;
      stat_kill_q  <= stat_kill_d;
    end
  end

  assign bus.stat_stall_cnt = stat_stall_q;
  assign bus.stat_kill_cnt  = stat_kill_q;
`else
  assign bus.stat_stall_cnt = 32'd0;
  assign bus.stat_kill_cnt  = 16'd0;
`endif
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter (DEPTH=2, STARVE_LIMIT=4): vector table plus
// hand-written reset and starvation sequences.
module tb_wb_write_arbiter;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  wb_write_arbiter_if bus();

  wb_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        w_we;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic        late_valid;
    logic [4:0]  late_addr;
    logic [31:0] late_data;
    logic [4:0]  q_addr;
    logic        e_ready;
    logic        e_qp;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_stall;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                             input logic lv, input logic [4:0] la, input logic [31:0] ld,
                             input logic [4:0] qa, input logic rdy, input logic qp,
                             input logic ewe, input logic [4:0] ea, input logic [31:0] ed,
                             input logic est);
    vec_t r;
    r.w_we = we; r.w_addr = wa; r.w_data = wd;
    r.late_valid = lv; r.late_addr = la; r.late_data = ld; r.q_addr = qa;
    r.e_ready = rdy; r.e_qp = qp; r.e_we = ewe; r.e_addr = ea; r.e_data = ed; r.e_stall = est;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    bus.w_we = we; bus.w_addr = wa; bus.w_data = wd;
    bus.late_valid = lv; bus.late_addr = la; bus.late_data = ld;
  endtask

  initial begin
    logic [31:0] exp_stall_stat;
    logic [15:0] exp_kill_stat;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    bus.q_addr = 5'd0;
    #2;
    check("rst_grf_we", bus.grf_we, 1'b0);
    check("rst_late_ready", bus.late_ready, 1'b1);
    check("rst_stall", bus.stall_req, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    for (int a = 0; a < 32; a++) begin
      bus.q_addr = 5'(a);
      #0.1;
      check($sformatf("idle_qp_%0d", a), bus.q_pending, 1'b0);
    end
    check("idle_grf_we", bus.grf_we, 1'b0);
    check("idle_grf_addr", bus.grf_addr, 5'd0);
    check("idle_grf_data", bus.grf_data, 32'd0);

    // late return, fill-and-starve, kill, $0 handling
    vecs.push_back(v(0, 0, 0,           0, 0, 0,           8, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0,           1, 8, 32'hDEADBEEF, 8, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0,           0, 0, 0,           8, 1, 1, 1, 8, 32'hDEADBEEF, 0));
    vecs.push_back(v(0, 0, 0,           0, 0, 0,           8, 1, 0, 0, 8, 32'hDEADBEEF, 0));
    vecs.push_back(v(1, 9, 32'h901,     1, 3, 32'h33333333, 3, 1, 0, 1, 9, 32'h901, 0));
    vecs.push_back(v(1, 9, 32'h902,     1, 4, 32'h44444444, 3, 1, 1, 1, 9, 32'h902, 0));
    vecs.push_back(v(1, 9, 32'h903,     1, 7, 32'h77777777, 4, 0, 1, 1, 9, 32'h903, 0));
    vecs.push_back(v(1, 9, 32'h904,     1, 7, 32'h77777777, 7, 0, 0, 1, 9, 32'h904, 0));
    vecs.push_back(v(1, 9, 32'h905,     0, 0, 0,           3, 0, 1, 1, 9, 32'h905, 1));
    vecs.push_back(v(0, 0, 0,           0, 0, 0,           3, 0, 1, 1, 3, 32'h33333333, 0));
    vecs.push_back(v(0, 0, 0,           0, 0, 0,           4, 1, 1, 1, 4, 32'h44444444, 0));
    vecs.push_back(v(0, 0, 0,           0, 0, 0,           4, 1, 0, 0, 4, 32'h44444444, 0));
    vecs.push_back(v(0, 0, 0,           1, 5, 32'h11111111, 5, 1, 0, 0, 4, 32'h44444444, 0));
    vecs.push_back(v(1, 5, 32'h22222222, 0, 0, 0,          5, 1, 1, 1, 5, 32'h22222222, 0));
    vecs.push_back(v(0, 0, 0,           0, 0, 0,           5, 1, 0, 0, 5, 32'h22222222, 0));
    vecs.push_back(v(1, 6, 32'h66660000, 1, 6, 32'h11116666, 6, 1, 0, 1, 6, 32'h66660000, 0));
    vecs.push_back(v(0, 0, 0,           0, 0, 0,           6, 1, 0, 0, 6, 32'h66660000, 0));
    vecs.push_back(v(1, 0, 32'hABCD0000, 1, 0, 32'h0BADF00D, 0, 1, 0, 0, 6, 32'h66660000, 0));
    vecs.push_back(v(0, 0, 0,           0, 0, 0,           0, 1, 0, 0, 6, 32'h66660000, 0));
    vecs.push_back(v(1, 0, 32'hABCD0001, 1, 10, 32'hA0A0A0A0, 10, 1, 0, 0, 6, 32'h66660000, 0));
    vecs.push_back(v(1, 0, 32'hABCD0002, 0, 0, 0,          10, 1, 1, 1, 10, 32'hA0A0A0A0, 0));
    vecs.push_back(v(0, 0, 0,           0, 0, 0,           10, 1, 0, 0, 10, 32'hA0A0A0A0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].w_we, vecs[i].w_addr, vecs[i].w_data,
            vecs[i].late_valid, vecs[i].late_addr, vecs[i].late_data);
      bus.q_addr = vecs[i].q_addr;
      #1;
      check($sformatf("v%0d_late_ready", i), bus.late_ready, vecs[i].e_ready);
      check($sformatf("v%0d_q_pending", i), bus.q_pending, vecs[i].e_qp);
      tick();
      check($sformatf("v%0d_grf_we", i), bus.grf_we, vecs[i].e_we);
      check($sformatf("v%0d_grf_addr", i), bus.grf_addr, vecs[i].e_addr);
      check($sformatf("v%0d_grf_data", i), bus.grf_data, vecs[i].e_data);
      check($sformatf("v%0d_stall", i), bus.stall_req, vecs[i].e_stall);
    end

`ifdef WB_ARB_STATS_EN
    exp_stall_stat = 32'd1;
    exp_kill_stat  = 16'd2;
`else
    exp_stall_stat = 32'd0;
    exp_kill_stat  = 16'd0;
`endif
    check("stat_stall_cnt", bus.stat_stall_cnt, exp_stall_stat);
    check("stat_kill_cnt", bus.stat_kill_cnt, {16'd0, exp_kill_stat});

    // two pending entries starve behind a busy pipeline, then reset mid-operation
    drive(1'b1, 5'd9, 32'h99999999, 1'b1, 5'd12, 32'hC0C0C0C0);
    tick();
    drive(1'b1, 5'd9, 32'h99999999, 1'b1, 5'd13, 32'hD0D0D0D0);
    tick();
    drive(1'b1, 5'd9, 32'h99999999, 1'b0, 5'd0, 32'd0);
    tick();
    check("pre_rst_stall_lo", bus.stall_req, 1'b0);
    tick();
    tick();
    bus.q_addr = 5'd12;
    #1;
    check("pre_rst_stall", bus.stall_req, 1'b1);
    check("pre_rst_full", bus.late_ready, 1'b0);
    check("pre_rst_qp", bus.q_pending, 1'b1);
    reset = 1'b1;
    #1;
    check("async_rst_grf_we", bus.grf_we, 1'b0);
    check("async_rst_grf_addr", bus.grf_addr, 5'd0);
    check("async_rst_grf_data", bus.grf_data, 32'd0);
    check("async_rst_stall", bus.stall_req, 1'b0);
    check("async_rst_ready", bus.late_ready, 1'b1);
    check("async_rst_qp", bus.q_pending, 1'b0);
    check("async_rst_stat_stall", bus.stat_stall_cnt, 32'd0);
    check("async_rst_stat_kill", bus.stat_kill_cnt, 32'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #2;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("post_rst_grf_we_%0d", c), bus.grf_we, 1'b0);
      check($sformatf("post_rst_qp_%0d", c), bus.q_pending, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
